// File: rtl/audio_pkg.sv
// Shared types and helpers for the soft-mute audio output conditioner.
package audio_pkg;

    typedef enum logic [2:0] {
        StOff,
        StHold,
        StBiasUp,
        StGainUp,
        StRun,
        StGainDown,
        StBiasDown
    } softmute_state_t;

    localparam logic [15:0] MIDSCALE = 16'h8000;
    localparam logic [8:0]  GAIN_ONE = 9'd256;

    // A 17-bit signed value can only exceed the 16-bit unsigned range on the negative side.
    function automatic logic [15:0] sat16u(input logic signed [16:0] v);
        if (v[16]) begin
            return 16'h0000;
        end
        return v[15:0];
    endfunction

endpackage

// File: rtl/audio_softmute_if.sv
// Sample/control bundle between the sound core, the soft-mute block and the DAC.
interface audio_softmute_if;
    logic        ce;
    logic        mute;
    logic [15:0] d_l;
    logic [15:0] d_r;
    logic [15:0] q_l;
    logic [15:0] q_r;
    logic        out_en;
    logic        busy;

    modport master (
        output ce, mute, d_l, d_r,
        input  q_l, q_r, out_en, busy
    );

    modport slave (
        input  ce, mute, d_l, d_r,
        output q_l, q_r, out_en, busy
    );
endinterface

// File: rtl/audio_gain_mul.sv
// One channel: signed sample times gain/256, plus DAC bias, clamped to offset-binary and
// registered on ce.
module audio_gain_mul
    import audio_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] d,
    input  logic [8:0]  gain,
    input  logic [15:0] bias,
    output logic [15:0] q
);

    logic signed [24:0] d_ext;
    logic signed [24:0] g_ext;
    logic signed [24:0] p;
    logic signed [16:0] s;
    logic signed [16:0] sum;
    logic [15:0]        q_q;

    always_comb begin
        d_ext = {{9{d[15]}}, d};
        g_ext = {16'b0, gain};
        p     = d_ext * g_ext;
        // gain <= 256 keeps the shifted product inside 17 bits.
        s     = 17'(p >>> 8);
        sum   = s + $signed({1'b0, bias});
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            q_q <= 16'h0000;
        end else if (ce) begin
            q_q <= sat16u(sum);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/audio_softmute.sv
// Sequenced power-up/power-down of the audio DAC path: hold, bias ramp, gain fade, run,
// and the reverse on mute.
module audio_softmute
    import audio_pkg::*;
#(
    parameter int unsigned HOLD_TICKS = 4194304,
    parameter int unsigned BIAS_STEP  = 1,
    parameter int unsigned GAIN_DIV   = 64
) (
    input logic clk_sys,
    input logic reset_n,
    audio_softmute_if.slave io
);

    localparam int unsigned TickMax = (HOLD_TICKS > GAIN_DIV) ? HOLD_TICKS : GAIN_DIV;
    localparam int unsigned TW      = $clog2(TickMax + 1);

    localparam logic [TW-1:0] HoldLast = TW'(HOLD_TICKS - 1);
    localparam logic [TW-1:0] GainLast = TW'(GAIN_DIV - 1);
    localparam logic [15:0]   Step     = 16'(BIAS_STEP);

    softmute_state_t state_q, state_d;
    logic [15:0]     bias_q, bias_d;
    logic [8:0]      gain_q, gain_d;
    logic [TW-1:0]   tick_q, tick_d;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= StOff;
            bias_q  <= 16'h0000;
            gain_q  <= 9'd0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            bias_q  <= bias_d;
            gain_q  <= gain_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bias_d  = bias_q;
        gain_d  = gain_q;
        tick_d  = tick_q;
        if (io.ce) begin
            case (state_q)
                StOff: begin
                    bias_d = 16'h0000;
                    gain_d = 9'd0;
                    tick_d = '0;
                    if (!io.mute) state_d = StHold;
                end
                StHold: begin
                    if (io.mute) begin
                        state_d = StOff;
                        tick_d  = '0;
                    end else if (tick_q == HoldLast) begin
                        state_d = StBiasUp;
                        tick_d  = '0;
                        bias_d  = Step;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StBiasUp: begin
                    // Mute freezes gain and bias; an empty gain skips the fade-out.
                    if (io.mute) begin
                        state_d = (gain_q == 9'd0) ? StBiasDown : StGainDown;
                        tick_d  = '0;
                    end else begin
                        bias_d = bias_q + Step;
                        if (bias_q == MIDSCALE - Step) begin
                            state_d = StGainUp;
                            tick_d  = '0;
                        end
                    end
                end
                StGainUp: begin
                    if (io.mute) begin
                        state_d = (gain_q == 9'd0) ? StBiasDown : StGainDown;
                        tick_d  = '0;
                    end else if (tick_q == GainLast) begin
                        tick_d = '0;
                        gain_d = gain_q + 9'd1;
                        if (gain_q == GAIN_ONE - 9'd1) state_d = StRun;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StRun: begin
                    gain_d = GAIN_ONE;
                    bias_d = MIDSCALE;
                    if (io.mute) begin
                        state_d = StGainDown;
                        tick_d  = '0;
                    end
                end
                StGainDown: begin
                    if (gain_q == 9'd0) begin
                        state_d = StBiasDown;
                        tick_d  = '0;
                    end else if (tick_q == GainLast) begin
                        tick_d = '0;
                        gain_d = gain_q - 9'd1;
                        if (gain_q == 9'd1) state_d = StBiasDown;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StBiasDown: begin
                    if (bias_q <= Step) begin
                        bias_d  = 16'h0000;
                        state_d = StOff;
                    end else begin
                        bias_d = bias_q - Step;
                    end
                end
                default: begin
                    state_d = StOff;
                end
            endcase
        end
    end

    assign io.out_en = !(state_q inside {StOff, StHold});
    assign io.busy   = !(state_q inside {StOff, StRun});

    // Channels see next-state gain/bias so a state change and its first sample coincide.
    audio_gain_mul u_mul_l (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce      (io.ce),
        .d       (io.d_l),
        .gain    (gain_d),
        .bias    (bias_d),
        .q       (io.q_l)
    );

    audio_gain_mul u_mul_r (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce      (io.ce),
        .d       (io.d_r),
        .gain    (gain_d),
        .bias    (bias_d),
        .q       (io.q_r)
    );

endmodule
